// File: rtl/spsram_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spsram_fifo_ctrl_pkg
// Shared defaults and SRAM control encodings used by spsram, the FIFO
// controller and the spsram_fifo wrapper.
//   BW_DATA_DEF / BW_ADDR_DEF : default data and address widths
//   WEN_WRITE / CEN_ON / OEN_ON: active levels of the SRAM control pins
//   sram_op_e                 : kind of SRAM access issued in a cycle
// -----------------------------------------------------------------------------
package spsram_fifo_ctrl_pkg;

    localparam int BW_DATA_DEF = 64;
    localparam int BW_ADDR_DEF = 6;

    localparam logic WEN_WRITE = 1'b1;
    localparam logic CEN_ON    = 1'b1;
    localparam logic OEN_ON    = 1'b1;

    typedef enum logic [1:0] {
        SRAM_IDLE  = 2'd0,
        SRAM_READ  = 2'd1,
        SRAM_WRITE = 2'd2
    } sram_op_e;

endpackage

// File: rtl/spsram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// spsram_fifo_ctrl_if
// Push/pop stream bundle of the FIFO. Signal names are from the controller's
// point of view (i_ = into the controller, o_ = out of it).
//   master : the FIFO user (drives push data/valid and pop ready)
//   slave  : the FIFO controller
// -----------------------------------------------------------------------------
interface spsram_fifo_ctrl_if
    import spsram_fifo_ctrl_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF,
    parameter int BW_ADDR = BW_ADDR_DEF
);
    logic               i_wr_valid;
    logic [BW_DATA-1:0] i_wr_data;
    logic               o_wr_ready;
    logic               o_rd_valid;
    logic [BW_DATA-1:0] o_rd_data;
    logic               i_rd_ready;
    logic [BW_ADDR+1:0] o_count;
    logic               o_full;

    modport master (
        output i_wr_valid, i_wr_data, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_rd_data, o_count, o_full
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_rd_data, o_count, o_full
    );
endinterface

// File: rtl/spsram.sv
// -----------------------------------------------------------------------------
// spsram
// Single-port synchronous SRAM, one access per cycle, read latency 1.
//   i_clk   : clock
//   i_data  : write data
//   i_addr  : word address
//   i_wen   : 1 = write, 0 = read (when enabled)
//   i_cen   : 1 = access this cycle
//   i_oen   : 1 = drive o_data, otherwise o_data reads 0
//   o_data  : read data, valid the cycle after the read address was sampled
// -----------------------------------------------------------------------------
module spsram
    import spsram_fifo_ctrl_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF,
    parameter int BW_ADDR = BW_ADDR_DEF
) (
    input  logic               i_clk,
    input  logic [BW_DATA-1:0] i_data,
    input  logic [BW_ADDR-1:0] i_addr,
    input  logic               i_wen,
    input  logic               i_cen,
    input  logic               i_oen,
    output logic [BW_DATA-1:0] o_data
);
    localparam int DEPTH = 1 << BW_ADDR;

    logic [BW_DATA-1:0] r_mem [DEPTH];
    logic [BW_DATA-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_cen == CEN_ON) begin
            if (i_wen == WEN_WRITE) begin
                r_mem[i_addr] <= i_data;
            end else begin
                r_data <= r_mem[i_addr];
            end
        end
    end

    assign o_data = (i_oen == OEN_ON) ? r_data : '0;
endmodule

// File: rtl/spsram_fifo.sv
// -----------------------------------------------------------------------------
// spsram_fifo
// Complete FIFO: spsram_fifo_ctrl driving one spsram instance.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   bus (slave)   : push/pop streams and status
// -----------------------------------------------------------------------------
module spsram_fifo
    import spsram_fifo_ctrl_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF,
    parameter int BW_ADDR = BW_ADDR_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    spsram_fifo_ctrl_if.slave bus
);
    logic [BW_DATA-1:0] w_sram_din;
    logic [BW_DATA-1:0] w_sram_dout;
    logic [BW_ADDR-1:0] w_sram_addr;
    logic               w_sram_wen;
    logic               w_sram_cen;
    logic               w_sram_oen;

    spsram_fifo_ctrl #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR)
    ) u_ctrl (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .bus         (bus),
        .o_sram_data (w_sram_din),
        .o_sram_addr (w_sram_addr),
        .o_sram_wen  (w_sram_wen),
        .o_sram_cen  (w_sram_cen),
        .o_sram_oen  (w_sram_oen),
        .i_sram_data (w_sram_dout)
    );

    spsram #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR)
    ) u_sram (
        .i_clk  (i_clk),
        .i_data (w_sram_din),
        .i_addr (w_sram_addr),
        .i_wen  (w_sram_wen),
        .i_cen  (w_sram_cen),
        .i_oen  (w_sram_oen),
        .o_data (w_sram_dout)
    );
endmodule

// File: rtl/spsram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// spsram_fifo_ctrl
// FIFO controller in front of a single-port SRAM. Push and pop streams are
// turned into at most one SRAM access per cycle; reads win over writes. Pop
// data is held in an output register so it stays stable while stalled.
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   bus (slave)    : push stream, pop stream, o_count, o_full
//   o_sram_*       : drive spsram i_data/i_addr/i_wen/i_cen/i_oen
//   i_sram_data    : spsram o_data
// -----------------------------------------------------------------------------
module spsram_fifo_ctrl
    import spsram_fifo_ctrl_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF,
    parameter int BW_ADDR = BW_ADDR_DEF
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    spsram_fifo_ctrl_if.slave  bus,
    output logic [BW_DATA-1:0] o_sram_data,
    output logic [BW_ADDR-1:0] o_sram_addr,
    output logic               o_sram_wen,
    output logic               o_sram_cen,
    output logic               o_sram_oen,
    input  logic [BW_DATA-1:0] i_sram_data
);
    localparam int               DEPTH    = 1 << BW_ADDR;
    localparam logic [BW_ADDR:0] MEM_FULL = DEPTH[BW_ADDR:0];

    logic [BW_ADDR-1:0] r_wr_ptr;
    logic [BW_ADDR-1:0] r_rd_ptr;
    logic [BW_ADDR:0]   r_mem_cnt;
    logic               r_rd_pend;
    logic               r_rd_vld;
    logic [BW_DATA-1:0] r_rd_data;

    logic     w_rd_gnt;
    logic     w_wr_ready;
    logic     w_wr_gnt;
    logic     w_pop;
    sram_op_e w_op;

    // A read is issued only when the output register will be free by the time
    // the data returns; the i_rstn terms keep the SRAM port quiet in reset.
    assign w_rd_gnt   = i_rstn && (r_mem_cnt != '0) && !r_rd_pend &&
                        (!r_rd_vld || bus.i_rd_ready);
    assign w_wr_ready = i_rstn && (r_mem_cnt != MEM_FULL) && !w_rd_gnt;
    assign w_wr_gnt   = bus.i_wr_valid && w_wr_ready;
    assign w_pop      = r_rd_vld && bus.i_rd_ready;

    always_comb begin
        w_op = SRAM_IDLE;
        if (w_rd_gnt) begin
            w_op = SRAM_READ;
        end else if (w_wr_gnt) begin
            w_op = SRAM_WRITE;
        end
    end

    always_comb begin
        o_sram_data = '0;
        o_sram_addr = '0;
        o_sram_wen  = ~WEN_WRITE;
        o_sram_cen  = ~CEN_ON;
        case (w_op)
            SRAM_READ: begin
                o_sram_addr = r_rd_ptr;
                o_sram_cen  = CEN_ON;
            end
            SRAM_WRITE: begin
                o_sram_addr = r_wr_ptr;
                o_sram_cen  = CEN_ON;
                o_sram_wen  = WEN_WRITE;
                o_sram_data = bus.i_wr_data;
            end
            default: ;
        endcase
    end

    // Output enable spans the address cycle and the data-return cycle.
    assign o_sram_oen = (w_rd_gnt || r_rd_pend) ? OEN_ON : ~OEN_ON;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_rd_gnt) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_gnt) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Grants are exclusive, so the count never moves both ways at once.
            if (w_rd_gnt) begin
                r_mem_cnt <= r_mem_cnt - 1'b1;
            end else if (w_wr_gnt) begin
                r_mem_cnt <= r_mem_cnt + 1'b1;
            end
            r_rd_pend <= w_rd_gnt;
            // Returning data always lands; it replaces a word popped this cycle.
            if (r_rd_pend) begin
                r_rd_data <= i_sram_data;
                r_rd_vld  <= 1'b1;
            end else if (w_pop) begin
                r_rd_vld  <= 1'b0;
            end
        end
    end

    assign bus.o_wr_ready = w_wr_ready;
    assign bus.o_rd_valid = r_rd_vld;
    assign bus.o_rd_data  = r_rd_data;
    assign bus.o_full     = (r_mem_cnt == MEM_FULL);
    assign bus.o_count    = {1'b0, r_mem_cnt}
                          + {{(BW_ADDR+1){1'b0}}, r_rd_pend}
                          + {{(BW_ADDR+1){1'b0}}, r_rd_vld};
endmodule

// File: tb/tb_spsram_fifo_ctrl.sv
module tb_spsram_fifo_ctrl;
    logic        clk;
    logic        rst_n;
    logic [63:0] sram_din;
    logic [5:0]  sram_addr;
    logic        sram_wen;
    logic        sram_cen;
    logic        sram_oen;
    logic [63:0] sram_dout;

    logic [63:0] sram_mem [64];
    logic [63:0] sram_q;

    logic [63:0] sb_q [$];
    int          checks;
    int          errors;
    int          pops;
    int          rd_mode;

    spsram_fifo_ctrl_if #(.BW_DATA(64), .BW_ADDR(6)) bus ();

    spsram_fifo_ctrl #(.BW_DATA(64), .BW_ADDR(6)) dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .bus         (bus),
        .o_sram_data (sram_din),
        .o_sram_addr (sram_addr),
        .o_sram_wen  (sram_wen),
        .o_sram_cen  (sram_cen),
        .o_sram_oen  (sram_oen),
        .i_sram_data (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (sram_cen) begin
            if (sram_wen) sram_mem[sram_addr] <= sram_din;
            else          sram_q <= sram_mem[sram_addr];
        end
    end
    assign sram_dout = sram_oen ? sram_q : 64'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pop-side ready: 0 = held low, 1 = held high, 2 = random each cycle.
    always begin
        @(posedge clk);
        #1;
        case (rd_mode)
            1:       bus.i_rd_ready = 1'b1;
            2:       bus.i_rd_ready = ($urandom_range(0, 1) == 1);
            default: bus.i_rd_ready = 1'b0;
        endcase
    end

    // Monitor: compares the DUT against the queue model each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 64'(bus.o_count), 64'(sb_q.size()));
            if (sram_cen && !sram_wen) chk("ready_in_read_cycle", 64'(bus.o_wr_ready), 64'd0);
            if (sram_cen && sram_wen) begin
                chk("write_without_accept", 64'(bus.i_wr_valid && bus.o_wr_ready), 64'd1);
                chk("sram_wdata", sram_din, bus.i_wr_data);
            end
            if (bus.o_full) chk("ready_when_full", 64'(bus.o_wr_ready), 64'd0);
            if (bus.o_rd_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_valid_with_empty_model actual=1 expected=0 at %0t", $time);
                end else begin
                    chk("rd_data", bus.o_rd_data, sb_q[0]);
                    if (bus.i_rd_ready) begin
                        void'(sb_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    // Offer one word until accepted or max_stall cycles pass; called at posedge+1.
    task automatic push_word(input logic [63:0] d, input int max_stall, output bit ok);
        int stall;
        stall = 0;
        ok = 1'b0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = d;
        while (!ok && stall < max_stall) begin
            @(negedge clk);
            if (bus.o_wr_ready) ok = 1'b1;
            else                stall++;
            @(posedge clk);
            if (ok) sb_q.push_back(d);
            #1;
        end
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while ((bus.o_count != 0 || sb_q.size() != 0 || bus.o_rd_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_count", 64'(bus.o_count), 64'd0);
        chk("drain_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        chk("drain_model_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int accepted;
        int pops0;
        int n;
        checks = 0;
        errors = 0;
        pops = 0;
        rd_mode = 0;
        rst_n = 1'b0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data = 64'h55;
        bus.i_rd_ready = 1'b0;

        // Reset with a push offered.
        #2;
        chk("rst_cen", 64'(sram_cen), 64'd0);
        chk("rst_wen", 64'(sram_wen), 64'd0);
        chk("rst_oen", 64'(sram_oen), 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_sram_data", sram_din, 64'd0);
        chk("rst_wr_ready", 64'(bus.o_wr_ready), 64'd0);
        chk("rst_count", 64'(bus.o_count), 64'd0);
        chk("rst_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        chk("rst_rd_data", bus.o_rd_data, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_wr_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_ready", 64'(bus.o_wr_ready), 64'd1);
        chk("post_rst_full", 64'(bus.o_full), 64'd0);
        @(posedge clk);
        #1;

        // Latency: push at T, read at T+1, valid at T+3.
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data = 64'hA5;
        @(negedge clk);
        chk("lat_T_ready", 64'(bus.o_wr_ready), 64'd1);
        chk("lat_T_wen", 64'(sram_wen), 64'd1);
        chk("lat_T_addr", 64'(sram_addr), 64'd0);
        @(posedge clk);
        sb_q.push_back(64'hA5);
        #1;
        bus.i_wr_valid = 1'b0;
        @(negedge clk);
        chk("lat_T1_cen", 64'(sram_cen), 64'd1);
        chk("lat_T1_wen", 64'(sram_wen), 64'd0);
        chk("lat_T1_addr", 64'(sram_addr), 64'd0);
        chk("lat_T1_oen", 64'(sram_oen), 64'd1);
        @(negedge clk);
        chk("lat_T2_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        @(negedge clk);
        chk("lat_T3_rd_valid", 64'(bus.o_rd_valid), 64'd1);
        chk("lat_T3_rd_data", bus.o_rd_data, 64'hA5);
        @(posedge clk);
        #1;
        rd_mode = 1;
        wait_empty(20);
        rd_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Fill with no pops: 64 in SRAM plus 1 in the output register.
        accepted = 0;
        for (int i = 0; i < 100; i++) begin
            push_word(64'(i), 20, ok);
            if (!ok) break;
            accepted++;
        end
        chk("fill_accepted", 64'(accepted), 64'd65);
        @(negedge clk);
        chk("fill_full", 64'(bus.o_full), 64'd1);
        chk("fill_count", 64'(bus.o_count), 64'd65);
        chk("fill_rd_valid", 64'(bus.o_rd_valid), 64'd1);
        chk("fill_rd_data", bus.o_rd_data, 64'd0);
        chk("fill_wr_ready", 64'(bus.o_wr_ready), 64'd0);
        @(posedge clk);
        #1;

        // Drain, with the stalled word 65 going in once space frees.
        pops0 = pops;
        rd_mode = 1;
        push_word(64'd65, 200, ok);
        chk("drain_push65_accepted", 64'(ok), 64'd1);
        wait_empty(400);
        chk("drain_pops", 64'(pops - pops0), 64'd66);
        rd_mode = 0;

        // Concurrent push/pop with random pop stalls.
        pops0 = pops;
        rd_mode = 2;
        for (int i = 0; i < 300; i++) begin
            push_word({$urandom, $urandom}, 100, ok);
            if (!ok) begin
                chk("conc_push_timeout", 64'(ok), 64'd1);
                break;
            end
        end
        rd_mode = 1;
        wait_empty(400);
        chk("conc_pops", 64'(pops - pops0), 64'd300);

        // Pointer wrap: 200 words streamed through.
        pops0 = pops;
        for (int i = 0; i < 200; i++) begin
            push_word(64'h1000 + 64'(i), 50, ok);
            if (!ok) begin
                chk("wrap_push_timeout", 64'(ok), 64'd1);
                break;
            end
        end
        wait_empty(400);
        chk("wrap_pops", 64'(pops - pops0), 64'd200);

        // Reset while a read is pending.
        rd_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        push_word(64'hDEAD, 10, ok);
        chk("pend_push_accepted", 64'(ok), 64'd1);
        n = 0;
        @(negedge clk);
        while (!(sram_oen && !sram_cen) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pend_seen", 64'(sram_oen && !sram_cen), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("pend_rst_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        chk("pend_rst_count", 64'(bus.o_count), 64'd0);
        chk("pend_rst_oen", 64'(sram_oen), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("pend_post_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        @(posedge clk);
        #1;
        pops0 = pops;
        push_word(64'h1, 10, ok);
        rd_mode = 1;
        wait_empty(20);
        chk("pend_post_pops", 64'(pops - pops0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spsram_fifo_ctrl.md
Name: spsram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of spsram and is the only master of its port.
- Converts a valid/ready push stream and a valid/ready pop stream into single-port SRAM accesses, one access per cycle.
- Drives spsram's i_data, i_addr, i_wen, i_cen and i_oen, and consumes its o_data.
- Holds one output data register so pop data is registered and stable while stalled.

Parameters:
- BW_DATA, 64, data word width; must match spsram BW_DATA.
- BW_ADDR, 6, SRAM address width; localparam DEPTH = 1<<BW_ADDR (64).

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rstn  input  1  asynchronous active-low reset.
- i_wr_valid  input  1  push request.
- i_wr_data  input  BW_DATA  push data.
- o_wr_ready  output  1  push accepted when i_wr_valid & o_wr_ready.
- o_rd_valid  output  1  o_rd_data holds the oldest entry.
- o_rd_data  output  BW_DATA  pop data (registered).
- i_rd_ready  input  1  pop when o_rd_valid & i_rd_ready.
- o_count  output  BW_ADDR+2  total entries held (SRAM + in-flight read + output register), 0..DEPTH+1.
- o_full  output  1  SRAM holds DEPTH entries.
- o_sram_data  output  BW_DATA  to spsram i_data.
- o_sram_addr  output  BW_ADDR  to spsram i_addr.
- o_sram_wen  output  1  to spsram i_wen (1 = write).
- o_sram_cen  output  1  to spsram i_cen (1 = enabled).
- o_sram_oen  output  1  to spsram i_oen (1 = output enabled).
- i_sram_data  input  BW_DATA  from spsram o_data.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: BW_ADDR each, natural wrap DEPTH-1 -> 0.
  - mem_cnt: BW_ADDR+1, 0..DEPTH.
  - rd_pend: 1 bit.
  - rd_vld: drives o_rd_valid.
  - rd_data: drives o_rd_data.
- Reset values: all of the above 0, so o_rd_valid=0, o_rd_data=0, o_count=0 and o_full=0. While i_rstn=0, every o_sram_* is forced to 0 and o_wr_ready=0.
- SRAM read latency is 1: the address is sampled at the edge ending cycle T, and i_sram_data is valid during T+1.
- Read grant (rd_gnt), evaluated combinationally each cycle: mem_cnt!=0 & !rd_pend & (!rd_vld | i_rd_ready). Read has priority over write.
- Write grant: wr_gnt = i_wr_valid & o_wr_ready.
- o_wr_ready = (mem_cnt!=DEPTH) & !rd_gnt.
- SRAM drive, combinational from the grants:
  - On rd_gnt: addr=rd_ptr, cen=1, wen=0.
  - On wr_gnt: addr=wr_ptr, cen=1, wen=1, o_sram_data=i_wr_data.
  - Otherwise cen=0, wen=0, addr=0, data=0.
  - o_sram_oen = rd_gnt | rd_pend.
- On rd_gnt: rd_ptr++, mem_cnt--, and rd_pend is set for the next cycle.
- On wr_gnt: wr_ptr++, mem_cnt++. rd_gnt and wr_gnt are mutually exclusive, so mem_cnt never moves +1 and -1 in the same cycle.
- While rd_pend=1: rd_data <= i_sram_data and rd_vld <= 1 at the end of that cycle; rd_pend clears.
- Pop without refill: rd_vld <= 0.
- Pop in the same cycle as the rd_pend capture: the captured data replaces the popped word; rd_vld stays 1.
- Latency: a push accepted in cycle T into an empty FIFO is read in T+1 and shows o_rd_valid=1 in T+3.
- Throughput: at most one read per 2 cycles (rd_pend blocks back-to-back reads). Writes fill all remaining cycles.
- o_count = mem_cnt + rd_pend + rd_vld. o_full = (mem_cnt==DEPTH).
- Full: when mem_cnt==DEPTH, o_wr_ready=0. A push offered then stalls with no state change and no data loss.
- Empty: when mem_cnt==0, no read is issued. A pop is only legal when o_rd_valid=1; i_rd_ready while o_rd_valid=0 is ignored.
- Reset mid-operation: pending read and output register are discarded, pointers and counters return to 0. SRAM contents are not cleared; stale data is unreachable.
- o_rd_data holds its value while o_rd_valid=1 and i_rd_ready=0.

Decomposition:
- Shared defines header holds BW_DATA/BW_ADDR defaults and the control-encoding constants WEN_WRITE=1, CEN_ON=1, OEN_ON=1. Both spsram and this block use them.
- No sub-module inside the controller.
- Separate top wrapper spsram_fifo instantiates spsram_fifo_ctrl plus one spsram.

Test Plan:
- Reset: i_rstn=0 with i_wr_valid=1 -> all o_sram_*=0, o_wr_ready=0, o_count=0. After release, o_wr_ready=1.
- Latency: push 64'hA5 at cycle T into empty FIFO -> read cycle T+1 shows o_sram_cen=1, o_sram_wen=0, o_sram_addr=0. o_rd_valid=1 and o_rd_data=64'hA5 at T+3.
- Fill: i_rd_ready=0, push 0..99 continuously -> 65 accepted (64 in SRAM + 1 in output register), o_full=1, o_count=65, push 65 stalls, o_rd_data=0.
- Drain order: after fill, i_rd_ready=1 -> 65 pops in order 0..64, stalled word 65 accepted once space frees, and it arrives in order. o_count ends at 0 and o_rd_valid=0.
- Concurrent: continuous push and pop for 300 words with random i_rd_ready -> o_wr_ready=0 in every read-grant cycle, scoreboard order exact, no loss or duplication.
- Wrap and reset: stream 200 words through, so pointers pass 63->0 three times, with data intact. Then reset with rd_pend=1 -> o_rd_valid=0, o_count=0, and the next push of 64'h1 pops as 64'h1.
